// File: rtl/status_pkg.sv
// Shared definitions for the 6502 status register: P bit positions, flag-op and
// branch-condition encodings, the reset image and P pack/unpack helpers.
package status_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_SEC = 3'd1;
  localparam logic [2:0] OP_CLC = 3'd2;
  localparam logic [2:0] OP_SEI = 3'd3;
  localparam logic [2:0] OP_CLI = 3'd4;
  localparam logic [2:0] OP_SED = 3'd5;
  localparam logic [2:0] OP_CLD = 3'd6;
  localparam logic [2:0] OP_CLV = 3'd7;

  localparam logic [1:0] COND_N = 2'b00;
  localparam logic [1:0] COND_V = 2'b01;
  localparam logic [1:0] COND_C = 2'b10;
  localparam logic [1:0] COND_Z = 2'b11;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

  // Only the six architectural flags are stored; bits 5 and 4 exist on the bus only.
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  function automatic logic [7:0] pack_p(input flags_t f);
    return {f.n, f.v, 1'b1, 1'b0, f.d, f.i, f.z, f.c};
  endfunction

  function automatic flags_t unpack_p(input logic [7:0] b);
    flags_t f;
    f.n = b[P_N];
    f.v = b[P_V];
    f.d = b[P_D];
    f.i = b[P_I];
    f.z = b[P_Z];
    f.c = b[P_C];
    return f;
  endfunction

endpackage

// File: rtl/status_if.sv
// Signal bundle between the status register (slave) and the sequencer/ALU/stack
// path that drives it (master).
interface status_if;
  logic       alu_n;
  logic       alu_v;
  logic       alu_z;
  logic       alu_c;
  logic [3:0] flag_we;
  logic [2:0] op;
  logic       pull_valid;
  logic [7:0] pull_data;
  logic       irq_entry;
  logic       brk_push;
  logic       instr_done;
  logic [2:0] cond;
  logic [7:0] p;
  logic [7:0] push_data;
  logic       carry_in;
  logic       daa;
  logic       irq_mask;
  logic       branch_taken;

  modport master (
    output alu_n, alu_v, alu_z, alu_c, flag_we, op, pull_valid, pull_data,
           irq_entry, brk_push, instr_done, cond,
    input  p, push_data, carry_in, daa, irq_mask, branch_taken
  );

  modport slave (
    input  alu_n, alu_v, alu_z, alu_c, flag_we, op, pull_valid, pull_data,
           irq_entry, brk_push, instr_done, cond,
    output p, push_data, carry_in, daa, irq_mask, branch_taken
  );
endinterface

// File: rtl/status_branch_eval.sv
// Combinational branch decision: select one of N/V/C/Z by cond[2:1] and compare
// it with the required value in cond[0].
module status_branch_eval
  import status_pkg::*;
(
  input  logic       i_n,
  input  logic       i_v,
  input  logic       i_c,
  input  logic       i_z,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  logic w_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sel = i_n;
    case (i_cond[2:1])
      COND_N:  w_sel = i_n;
      COND_V:  w_sel = i_v;
      COND_C:  w_sel = i_c;
      COND_Z:  w_sel = i_z;
      default: w_sel = i_n;
    endcase
  end

  assign o_taken = (w_sel == i_cond[0]);

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register with ALU flag capture, flag ops, stack images,
// interrupt masking and branch evaluation. Define STATUS_BCD_EN to drive daa from D.
module status_reg
  import status_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input logic     clk,
  input logic     rst_n,
  status_if.slave bus
);

  flags_t     r_flags;
  flags_t     w_flags_nxt;
  logic       r_irq_mask;
  logic [7:0] w_p;

  // Priority: pull, then op over same-flag ALU writes, then irq_entry forcing I.
  always_comb begin
    w_flags_nxt = r_flags;
    if (bus.pull_valid) begin
      w_flags_nxt = unpack_p(bus.pull_data);
    end else begin
      if (bus.flag_we[3]) w_flags_nxt.n = bus.alu_n;
      if (bus.flag_we[2]) w_flags_nxt.v = bus.alu_v;
      if (bus.flag_we[1]) w_flags_nxt.z = bus.alu_z;
      if (bus.flag_we[0]) w_flags_nxt.c = bus.alu_c;
      case (bus.op)
        OP_SEC:  w_flags_nxt.c = 1'b1;
        OP_CLC:  w_flags_nxt.c = 1'b0;
        OP_SEI:  w_flags_nxt.i = 1'b1;
        OP_CLI:  w_flags_nxt.i = 1'b0;
        OP_SED:  w_flags_nxt.d = 1'b1;
        OP_CLD:  w_flags_nxt.d = 1'b0;
        OP_CLV:  w_flags_nxt.v = 1'b0;
        default: ;
      endcase
    end
    if (bus.irq_entry) w_flags_nxt.i = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags    <= unpack_p(RESET_P);
      r_irq_mask <= 1'b1;
    end else begin
      r_flags <= w_flags_nxt;
      // The mask trails I by one instruction boundary so CLI/SEI/PLP act one instruction late.
      if (bus.irq_entry)       r_irq_mask <= 1'b1;
      else if (bus.instr_done) r_irq_mask <= r_flags.i;
    end
  end

  assign w_p           = pack_p(r_flags);
  assign bus.p         = w_p;
  assign bus.push_data = {w_p[7:5], bus.brk_push, w_p[3:0]};
  assign bus.carry_in  = r_flags.c;
  assign bus.irq_mask  = r_irq_mask;

`ifdef STATUS_BCD_EN
  assign bus.daa = r_flags.d;
`else
  assign bus.daa = 1'b0;
`endif

  status_branch_eval u_branch (
    .i_n     (r_flags.n),
    .i_v     (r_flags.v),
    .i_c     (r_flags.c),
    .i_z     (r_flags.z),
    .i_cond  (bus.cond),
    .o_taken (bus.branch_taken)
  );

endmodule

// File: doc/status_reg.md
# status_reg

- Holds the 6502 processor status register (P) and consumes the ALU flag outputs N, V, Z and CO.
- Feeds the ALU's CI and DAA inputs back from the C and D flags.
- Applies flag set/clear instructions, stack pull/push images, interrupt-entry masking and branch-condition evaluation.
- Sits between the ALU, the instruction sequencer and the stack/data bus path in the CPU core.

## Interface
Parameters:
- RESET_P, 8'h24, P value after reset (bit5 = 1, I = 1, all other flags clear).

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_n, alu_v, alu_z, alu_c  in  1 each  ALU result flags (alu_z = 1 means the result is zero)
- flag_we  in  4  per-flag ALU write enables {N,V,Z,C}
- op  in  3  flag op: 0 NOP, 1 SEC, 2 CLC, 3 SEI, 4 CLI, 5 SED, 6 CLD, 7 CLV
- pull_valid  in  1  load P from pull_data (PLP/RTI)
- pull_data  in  8  stack byte; bits 5 and 4 are ignored
- irq_entry  in  1  interrupt/BRK entry; sets I
- brk_push  in  1  sets the B bit in push_data
- instr_done  in  1  instruction-boundary strobe
- cond  in  3  branch select: [2:1] 00 N, 01 V, 10 C, 11 Z; [0] required value
- p  out  8  {N,V,1,0,D,I,Z,C}
- push_data  out  8  p with bit4 = brk_push
- carry_in  out  1  to ALU CI (= C)
- daa  out  1  to ALU DAA (= D, subject to configuration)
- irq_mask  out  1  IRQ inhibit seen by the interrupt logic
- branch_taken  out  1  selected flag == cond[0]

## Operation
- Stored state: six flag flops (N V D I Z C) plus the irq_mask flop. Bits 5 and 4 are not stored.
- Per-cycle update priority, highest first:
  - pull_valid: loads all six flags from pull_data; op and flag_we are ignored that cycle.
  - op: sets or clears its single flag.
  - flag_we: loads each enabled flag from its alu_* input, unless op targets the same flag that cycle, in which case op wins.
  - irq_entry: forces I = 1 after all of the above, including over CLI or a pull with I = 0.
- flag_we bits and op on different flags apply together in the same cycle.
- The ALU drives only N V Z C. D and I change only via op, pull_valid or irq_entry.
- irq_mask:
  - On an instr_done cycle, irq_mask loads the I value held before that edge. CLI/SEI/PLP therefore take effect one instruction late.
  - irq_entry sets irq_mask = 1 on the same edge, regardless of instr_done.
- branch_taken, carry_in, daa, p and push_data are combinational from the stored flops only, never from same-cycle inputs.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert at the top level):
  - p = RESET_P, push_data = 8'h24 (brk_push = 0), irq_mask = 1, carry_in = 0, daa = 0.
  - branch_taken follows cond: taken for cond 3'b000, 3'b010, 3'b100, 3'b110.
- Flag updates are visible on p, carry_in, daa and branch_taken one cycle after the input cycle.
- Back-to-back updates on consecutive cycles all apply. There are no stalls and no handshake; every input is a single-cycle qualifier.
- Reset mid-instruction discards any pending update. irq_mask returns to 1 immediately.

## Configuration
- STATUS_BCD_EN defined: daa = D; SED/CLD/pull modify D.
- STATUS_BCD_EN undefined (2A03-style):
  - D is still stored and pushed, and SED/CLD/pull still modify it.
  - daa is tied 0, so the ALU never performs decimal addition.

## Structure
- Shared package status_pkg holds:
  - flag bit-index constants (P_C = 0 … P_N = 7);
  - the op encoding localparams;
  - the cond encoding;
  - the RESET_P default value.
- One sub-module, status_branch_eval: a purely combinational 4:1 flag select and compare producing branch_taken.

## Test plan
- Reset release: p = 8'h24, irq_mask = 1, branch_taken = 1 with cond = 3'b000.
- flag_we = 4'b1111 with alu {N,V,Z,C} = 1,0,1,1, then op = CLC on the next cycle: p = 8'hA7, then 8'hA6; carry_in follows 1 then 0.
- Same cycle: op = SEC with flag_we[C] = 1, alu_c = 0, plus pull_valid = 1, pull_data = 8'hFF. Result p = 8'hEF (pull wins, bit4 cleared).
- CLI with instr_done on cycle k: irq_mask stays 1 at k+1 and goes 0 only after the next instr_done. irq_entry then sets I and irq_mask in one edge.
- Bits 5 and 4 handling:
  - brk_push = 1 with p = 8'h24: push_data = 8'h34.
  - pull_data = 8'h10: p = 8'h20.
- SED, then read daa: 1 with STATUS_BCD_EN, 0 without; p[3] = 1 in both builds.
